// File: rtl/gpio_pkg.sv
// Shared constants for the memory-mapped GPIO block: register offsets,
// window size and bus data width.
package gpio_pkg;

    localparam int GPIO_WIN = 8;
    localparam int GPIO_DW  = 32;

    localparam logic [2:0] GPIO_DIR  = 3'd0;
    localparam logic [2:0] GPIO_MASK = 3'd1;
    localparam logic [2:0] GPIO_OUT  = 3'd2;
    localparam logic [2:0] GPIO_IN   = 3'd3;
    localparam logic [2:0] GPIO_IE   = 3'd4;
    localparam logic [2:0] GPIO_EDGE = 3'd5;
    localparam logic [2:0] GPIO_STAT = 3'd6;
    localparam logic [2:0] GPIO_RSVD = 3'd7;

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop synchroniser plus one history flop per pin; reports the
// synchronised level and single-cycle rise/fall pulses.
module gpio_sync_edge #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] sync,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] s1_q, s1_d;
    logic [W-1:0] s2_q, s2_d;
    logic [W-1:0] s3_q, s3_d;

    always_comb begin
        s1_d = din;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign sync = s2_q;
    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO peripheral on the core data port: direction/mask/output registers,
// synchronised input readback and sticky edge interrupts with W1C status.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int                PIN    = 8,
    parameter int                ADDR_W = 7,
    parameter logic [ADDR_W-1:0] BASE   = 7'h78
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  addr,
    input  logic               wen,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    input  logic [PIN-1:0]     gpio_in,
    output logic [PIN-1:0]     gpio_out,
    output logic [PIN-1:0]     gpio_oe,
    output logic               irq
);

    logic [PIN-1:0] dir_q,  dir_d;
    logic [PIN-1:0] mask_q, mask_d;
    logic [PIN-1:0] out_q,  out_d;
    logic [PIN-1:0] ie_q,   ie_d;
    logic [PIN-1:0] edge_q, edge_d;
    logic [PIN-1:0] stat_q, stat_d;

    logic [PIN-1:0] in_sync, in_rise, in_fall;
    logic [PIN-1:0] evt, clr, rd_val;
    logic           in_win, wr;
    logic [2:0]     off;

    // Only the low PIN bits of the write bus carry register data.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    gpio_sync_edge #(.W(PIN)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (gpio_in),
        .sync (in_sync),
        .rise (in_rise),
        .fall (in_fall)
    );

    // BASE is 8-aligned, so the window is selected by the upper address bits.
    assign in_win = (addr[ADDR_W-1:3] == BASE[ADDR_W-1:3]);
    assign off    = addr[2:0];
    assign wr     = wen && in_win;

    assign evt = ie_q & ((edge_q & in_rise) | (~edge_q & in_fall));
    assign clr = (wr && off == GPIO_STAT) ? wdata[PIN-1:0] : '0;

    always_comb begin
        dir_d  = dir_q;
        mask_d = mask_q;
        out_d  = out_q;
        ie_d   = ie_q;
        edge_d = edge_q;
        if (wr) begin
            case (off)
                GPIO_DIR:  dir_d  = wdata[PIN-1:0];
                GPIO_MASK: mask_d = wdata[PIN-1:0];
                GPIO_OUT:  out_d  = wdata[PIN-1:0];
                GPIO_IE:   ie_d   = wdata[PIN-1:0];
                GPIO_EDGE: edge_d = wdata[PIN-1:0];
                default:   ;
            endcase
        end
        // A new event outranks a simultaneous clear so no edge is lost.
        stat_d = (stat_q & ~clr) | evt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q  <= '0;
            mask_q <= '0;
            out_q  <= '0;
            ie_q   <= '0;
            edge_q <= '0;
            stat_q <= '0;
        end else begin
            dir_q  <= dir_d;
            mask_q <= mask_d;
            out_q  <= out_d;
            ie_q   <= ie_d;
            edge_q <= edge_d;
            stat_q <= stat_d;
        end
    end

    always_comb begin
        rd_val = '0;
        case (off)
            GPIO_DIR:  rd_val = dir_q;
            GPIO_MASK: rd_val = mask_q;
            GPIO_OUT:  rd_val = out_q;
            GPIO_IN:   rd_val = in_sync;
            GPIO_IE:   rd_val = ie_q;
            GPIO_EDGE: rd_val = edge_q;
            GPIO_STAT: rd_val = stat_q;
            default:   rd_val = '0;
        endcase
        rdata = '0;
        if (in_win) rdata[PIN-1:0] = rd_val;
    end

    assign gpio_out = out_q & mask_q & dir_q;
    assign gpio_oe  = dir_q;
    assign irq      = |(stat_q & ie_q);

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: register table, input latency,
// edge interrupts, masking and the set/clear collision.
module tb_gpio_ctrl;

    localparam int         PIN  = 8;
    localparam logic [6:0] BASE = 7'h78;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  addr;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic        irq;

    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    gpio_ctrl #(.PIN(PIN), .ADDR_W(7), .BASE(BASE)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wen      (wen),
        .wdata    (wdata),
        .rdata    (rdata),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic sb_check(input string nm, input logic [31:0] act);
        logic [31:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: got %h but no expected value queued", nm, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h", nm, act, e);
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wen   = 1'b1;
        wdata = d;
        @(posedge clk);
        #1;
        wen   = 1'b0;
        addr  = 7'h00;
    endtask

    task automatic wr_off(input logic [2:0] off, input logic [31:0] d);
        wr(BASE | {4'b0, off}, d);
    endtask

    task automatic read_chk(input logic [2:0] off, input logic [31:0] e, input string nm);
        expect_val(e);
        addr = BASE | {4'b0, off};
        #1;
        sb_check(nm, rdata);
        addr = 7'h00;
    endtask

    task automatic out_chk(input logic [7:0] e, input string nm);
        expect_val({24'b0, e});
        sb_check(nm, {24'b0, gpio_out});
    endtask

    task automatic oe_chk(input logic [7:0] e, input string nm);
        expect_val({24'b0, e});
        sb_check(nm, {24'b0, gpio_oe});
    endtask

    task automatic irq_chk(input logic e, input string nm);
        expect_val({31'b0, e});
        sb_check(nm, {31'b0, irq});
    endtask

    task automatic drive_in(input logic [7:0] v);
        @(negedge clk);
        gpio_in = v;
    endtask

    task automatic wait_edges(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]  off;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [7:0]  exp_out;
        logic [7:0]  exp_oe;
    } vec_t;

    vec_t vecs[10];

    initial begin
        rst     = 1'b0;
        addr    = 7'h00;
        wen     = 1'b0;
        wdata   = 32'h0;
        gpio_in = 8'h00;

        vecs[0] = '{3'd0, 32'h0000_000F, 32'h0000_000F, 8'h00, 8'h0F};
        vecs[1] = '{3'd1, 32'h0000_003C, 32'h0000_003C, 8'h00, 8'h0F};
        vecs[2] = '{3'd2, 32'h0000_00FF, 32'h0000_00FF, 8'h0C, 8'h0F};
        vecs[3] = '{3'd3, 32'h0000_00AA, 32'h0000_0000, 8'h0C, 8'h0F};
        vecs[4] = '{3'd7, 32'h0000_00FF, 32'h0000_0000, 8'h0C, 8'h0F};
        vecs[5] = '{3'd5, 32'h0000_00A5, 32'h0000_00A5, 8'h0C, 8'h0F};
        vecs[6] = '{3'd5, 32'h0000_0000, 32'h0000_0000, 8'h0C, 8'h0F};
        vecs[7] = '{3'd0, 32'hFFFF_FFFF, 32'h0000_00FF, 8'h3C, 8'hFF};
        vecs[8] = '{3'd2, 32'h0000_0081, 32'h0000_0081, 8'h00, 8'hFF};
        vecs[9] = '{3'd1, 32'h0000_00FF, 32'h0000_00FF, 8'h81, 8'hFF};

        // ---- reset with a competing write ----
        @(negedge clk);
        rst   = 1'b1;
        wen   = 1'b1;
        addr  = BASE | 7'd2;
        wdata = 32'h0000_00FF;
        wait_edges(2);
        @(negedge clk);
        rst  = 1'b0;
        wen  = 1'b0;
        addr = 7'h00;
        #1;
        out_chk(8'h00, "rst_gpio_out");
        oe_chk(8'h00, "rst_gpio_oe");
        irq_chk(1'b0, "rst_irq");
        for (int i = 0; i < 8; i++) read_chk(3'(i), 32'h0, $sformatf("rst_rd%0d", i));

        // ---- table-driven register / output gating ----
        for (int i = 0; i < 10; i++) begin
            wr_off(vecs[i].off, vecs[i].wdata);
            read_chk(vecs[i].off, vecs[i].exp_rd, $sformatf("tbl%0d_rd", i));
            out_chk(vecs[i].exp_out, $sformatf("tbl%0d_out", i));
            oe_chk(vecs[i].exp_oe, $sformatf("tbl%0d_oe", i));
        end

        // ---- write outside the window is ignored ----
        wr(7'h72, 32'h0000_0000);
        read_chk(3'd2, 32'h0000_0081, "oow_out_reg");
        out_chk(8'h81, "oow_gpio_out");

        // ---- input readback latency ----
        drive_in(8'h5A);
        wait_edges(1);
        read_chk(3'd3, 32'h0, "in_after_k");
        wait_edges(1);
        read_chk(3'd3, 32'h5A, "in_after_k1");
        read_chk(3'd6, 32'h0, "in_no_stat");

        // ---- rising-edge irq and W1C ----
        drive_in(8'h00);
        wait_edges(4);
        wr_off(3'd4, 32'h01);
        wr_off(3'd5, 32'h01);
        drive_in(8'h01);
        wait_edges(1);
        irq_chk(1'b0, "rise_irq_k");
        wait_edges(1);
        irq_chk(1'b0, "rise_irq_k1");
        wait_edges(1);
        irq_chk(1'b1, "rise_irq_k2");
        read_chk(3'd6, 32'h01, "rise_stat");
        wr_off(3'd6, 32'h01);
        read_chk(3'd6, 32'h00, "w1c_stat");
        irq_chk(1'b0, "w1c_irq");

        // ---- falling edge and masking ----
        drive_in(8'h02);
        wait_edges(4);
        wr_off(3'd4, 32'h02);
        wr_off(3'd5, 32'h00);
        read_chk(3'd6, 32'h00, "fall_pre_stat");
        drive_in(8'h00);
        wait_edges(3);
        read_chk(3'd6, 32'h02, "fall_stat");
        irq_chk(1'b1, "fall_irq");
        for (int i = 0; i < 6; i++) drive_in(gpio_in ^ 8'h04);
        wait_edges(4);
        read_chk(3'd6, 32'h02, "mask_stat");
        wr_off(3'd4, 32'h00);
        read_chk(3'd6, 32'h02, "ie_clr_stat_kept");
        irq_chk(1'b0, "ie_clr_irq");
        wr_off(3'd6, 32'h02);
        read_chk(3'd6, 32'h00, "fall_w1c");

        // ---- set/clear collision ----
        wr_off(3'd4, 32'h01);
        wr_off(3'd5, 32'h01);
        drive_in(8'h01);
        wait_edges(3);
        read_chk(3'd6, 32'h01, "col_pre_stat");
        drive_in(8'h00);
        wait_edges(4);
        read_chk(3'd6, 32'h01, "col_fall_ignored");
        drive_in(8'h01);
        @(posedge clk);
        @(posedge clk);
        wr_off(3'd6, 32'h01);
        read_chk(3'd6, 32'h01, "col_stat");
        irq_chk(1'b1, "col_irq");
        wr_off(3'd6, 32'h01);
        read_chk(3'd6, 32'h00, "col_after_clr");
        irq_chk(1'b0, "col_after_irq");

        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: %0d expected values left unchecked", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
